// File: rtl/lighthouse_sync_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | lighthouse_sync_decoder : decodes sync A/B pulse widths into OOTX bits,     |
// | picks the sweeping base station and emits one tagged sweep per frame.       |
// | Optional statistics counters: define LH_DECODE_STATS_EN.                    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module lighthouse_sync_decoder #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SYNC_BASE     = 1000,
  parameter int SYNC_STEP     = 167
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] sync_A_time,
  input  logic [COUNTER_WIDTH-1:0] sync_B_time,
  input  logic [COUNTER_WIDTH-1:0] sweep_time,
  input  logic                     complete,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_station,
  output logic                     out_axis,
  output logic                     out_data_a,
  output logic                     out_data_b,
  output logic [COUNTER_WIDTH-1:0] out_sweep,
  output logic [15:0]              frame_count,
  output logic [15:0]              drop_count
);

  localparam logic [COUNTER_WIDTH-1:0] C_T0   = COUNTER_WIDTH'(SYNC_BASE - SYNC_STEP / 2);
  localparam logic [COUNTER_WIDTH-1:0] C_STEP = COUNTER_WIDTH'(SYNC_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEC_A  = 2'd1,
    DEC_B  = 2'd2,
    SELECT = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic                       r_complete_q;
  logic                       r_new_frame;
  logic [3:0]                 r_k;
  logic [COUNTER_WIDTH-1:0]   r_thr;
  logic [COUNTER_WIDTH-1:0]   r_width;
  logic [COUNTER_WIDTH-1:0]   r_sync_b;
  logic [COUNTER_WIDTH-1:0]   r_sweep;
  logic [2:0]                 r_code;
  logic                       r_valid_lo;
  logic [2:0]                 r_code_a;
  logic                       r_valid_a;
  logic [2:0]                 r_code_b;
  logic                       r_valid_b;

  logic w_ge;
  logic w_last;
  logic w_decoding;
  logic w_sel_a;
  logic w_sel_b;
  logic w_load;

  assign w_ge       = (r_width >= r_thr);
  assign w_last     = (r_k == 4'd8);
  assign w_decoding = (r_state == DEC_A) || (r_state == DEC_B);
  assign w_sel_a    = r_valid_a & ~r_code_a[2];
  assign w_sel_b    = r_valid_b & ~r_code_b[2];
  assign w_load     = (r_state == SELECT) & (w_sel_a | w_sel_b) & (~out_valid | out_ready);

  // Registered edge pulse: a level already high when reset releases never counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_complete_q <= 1'b1;
      r_new_frame  <= 1'b0;
    end else begin
      r_complete_q <= complete;
      r_new_frame  <= complete & ~r_complete_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_new_frame) w_next = DEC_A;
      DEC_A:   if (w_last) w_next = DEC_B;
      DEC_B:   if (w_last) w_next = SELECT;
      SELECT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // One threshold per cycle: k=0 checks the lower bound, k=1..7 count code steps,
  // k=8 checks the upper bound and hands off to the next sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k        <= '0;
      r_thr      <= '0;
      r_width    <= '0;
      r_sync_b   <= '0;
      r_sweep    <= '0;
      r_code     <= '0;
      r_valid_lo <= 1'b0;
      r_code_a   <= '0;
      r_valid_a  <= 1'b0;
      r_code_b   <= '0;
      r_valid_b  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (r_new_frame) begin
        r_width  <= sync_A_time;
        r_sync_b <= sync_B_time;
        r_sweep  <= sweep_time;
        r_thr    <= C_T0;
        r_k      <= '0;
      end
    end else if (w_decoding) begin
      if (w_last) begin
        r_k   <= '0;
        r_thr <= C_T0;
        if (r_state == DEC_A) begin
          r_code_a  <= r_code;
          r_valid_a <= r_valid_lo & ~w_ge;
          r_width   <= r_sync_b;
        end else begin
          r_code_b  <= r_code;
          r_valid_b <= r_valid_lo & ~w_ge;
        end
      end else begin
        r_k   <= r_k + 4'd1;
        r_thr <= r_thr + C_STEP;
        if (r_k == 4'd0) begin
          r_valid_lo <= w_ge;
          r_code     <= '0;
        end else begin
          r_code <= r_code + {2'b00, w_ge};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_station <= 1'b0;
      out_axis    <= 1'b0;
      out_data_a  <= 1'b0;
      out_data_b  <= 1'b0;
      out_sweep   <= '0;
    end else if (w_load) begin
      out_valid   <= 1'b1;
      out_station <= ~w_sel_a;
      out_axis    <= w_sel_a ? r_code_a[0] : r_code_b[0];
      out_data_a  <= r_valid_a & r_code_a[1];
      out_data_b  <= r_valid_b & r_code_b[1];
      out_sweep   <= r_sweep;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef LH_DECODE_STATS_EN
  logic        w_drop;
  logic [15:0] r_frame_count;
  logic [15:0] r_drop_count;

  assign w_drop = (r_state == SELECT) & ~w_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_load && (r_frame_count != 16'hFFFF)) r_frame_count <= r_frame_count + 16'd1;
      if (w_drop && (r_drop_count != 16'hFFFF))  r_drop_count  <= r_drop_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/lighthouse_sync_decoder.md
# lighthouse_sync_decoder

Consumes one completed sync/sync/sweep measurement frame from the lighthouse timer and decodes each sync pulse width into its OOTX (skip, data, axis) bits. It selects which base station owns the sweep, then presents one tagged sweep result per frame on a valid/ready output to the position-solver stage. Width classification is done iteratively, one threshold compare per cycle; there are no dividers.

## Interface
- COUNTER_WIDTH, 32, width of all time inputs and `out_sweep`
- SYNC_BASE, 1000, clocks for code-0 sync width (62.5 µs at 16 clk/µs)
- SYNC_STEP, 167, clocks per code step (10.4 µs)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sync_A_time  in  COUNTER_WIDTH  first sync pulse width, clocks
- sync_B_time  in  COUNTER_WIDTH  second sync pulse width, 0 = absent
- sweep_time  in  COUNTER_WIDTH  sweep centre time from sync A
- complete  in  1  level; a rising edge marks a new frame
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_station  out  1  0 = station A swept, 1 = B
- out_axis  out  1  axis bit of sweeping station
- out_data_a / out_data_b  out  1 each  OOTX data bit of each sync, 0 if invalid
- out_sweep  out  COUNTER_WIDTH  captured sweep_time
- frame_count, drop_count  out  16 each  statistics (see Configuration)

## Operation
- Edge detect: `complete_q` register resets to 1, so a level held high through reset is not a frame. A new frame is `complete & ~complete_q`.
- On a new frame in IDLE, capture all three time inputs into local registers and go to DEC_A. Rising edges seen outside IDLE are ignored.
- Thresholds: t_k = SYNC_BASE + k·SYNC_STEP − SYNC_STEP/2 (integer divide), k = 0..8. Defaults: t_0 = 917, t_k = 917 + 167k, t_8 = 2253.
- Width w is valid iff t_0 ≤ w < t_8. Its code is the count of k ∈ 1..7 with w ≥ t_k.
- Code bits: code[2] = skip, code[1] = data, code[0] = axis.
- All compares are unsigned at COUNTER_WIDTH bits; thresholds are computed at COUNTER_WIDTH bits.
- States:
  - IDLE → DEC_A on a new frame.
  - DEC_A: k steps 0..8, one compare per cycle (9 cycles) → DEC_B.
  - DEC_B: same procedure on sync B (9 cycles) → SELECT.
  - SELECT: 1 cycle → IDLE.
- Selection:
  - A valid and skip_A = 0 → station 0, axis_A.
  - Otherwise B valid and skip_B = 0 → station 1, axis_B.
  - Otherwise the frame is rejected and nothing is output.
  - If both are valid with skip = 0, A wins.
- Output register (one entry):
  - In SELECT, a selected frame loads when `!out_valid | out_ready`, and out_valid is set.
  - Otherwise the frame is an overflow drop; the held entry is unchanged.
  - A transfer happens when out_valid & out_ready. out_valid clears the next cycle unless a load occurs in the same cycle, in which case it stays high with the new data.
- Reset: all outputs 0, state IDLE, counters 0, `complete_q` = 1.

## Timing
- Latency: rise of complete sampled at edge E → out_valid high after edge E+20. This is fixed regardless of data.
- Throughput: one frame per 21 cycles max. Upstream frames are ~8 ms apart.
- Outputs are registered and stable while out_valid & !out_ready.
- Reset asserted mid-decode aborts the frame; nothing is emitted.

## Configuration
- `LH_DECODE_STATS_EN` defined:
  - frame_count increments per frame loaded into the output.
  - drop_count increments per rejected or overflow frame.
  - Both are 16-bit and saturate at 0xFFFF.
- Undefined: both ports are driven constant 0 and no counter logic is synthesized. Decode behaviour is identical in both builds.

## Test plan
- A = 1000, B = 0, sweep = 50000, ready = 1 → out_valid 20 cycles after the rise; station 0, axis 0, data_a 0, data_b 0, sweep 50000.
- A = 1700 (code 4, skip), B = 1250 (code 1) → station 1, axis 1, data_a 0, data_b 0.
- A = 916 and A = 2253 (both invalid), B = 0 → no output; drop_count = 1 per frame with STATS_EN.
- A = 1418 (code 3) held with ready = 0, second frame A = 1000 → first entry kept (axis 1, data_a 1), second dropped, drop_count 1, frame_count 1.
- complete held high across reset release → no frame. Reset pulsed at cycle 10 of decode → out_valid stays 0.
- Boundaries: A = 1083 → code 0; A = 1084 → code 1; A = 2252 → code 7.
